// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC/nPC update sequencer (reset entry, DCTI annul, trap entry); optional PCSEQ_ALIGN_CHECK_EN
module pc_sequencer #(
    parameter int TRAP_CYCLES = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Step,
    input  logic       Branch,
    input  logic       Cond_True,
    input  logic       Branch_Always,
    input  logic       Annul_Bit,
    input  logic       Trap,
    input  logic [1:0] Target_Low,
    output logic [1:0] MUX_PC,
    output logic [1:0] MUX_nPC,
    output logic       PC_Ld,
    output logic       nPC_Ld,
    output logic       Annul,
    output logic       Save_PC,
    output logic       Save_nPC,
    output logic [1:0] State,
    output logic       Misalign
);

    localparam int CW = $clog2(TRAP_CYCLES);

    localparam logic [1:0] S_RESET = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_TRAP  = 2'b10;

    // Trap counter runs down from TRAP_CYCLES-1; the save strobes key off its first two values
    localparam logic [CW-1:0] CNT_START    = CW'(TRAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAVE_NPC = CW'(TRAP_CYCLES - 2);
    localparam logic [CW-1:0] CNT_ZERO     = '0;

    logic [1:0]    state_q, state_d;
    logic          annul_q, annul_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0] mux_pc;
    logic [1:0] mux_npc;
    logic       ld;
    logic       save_pc;
    logic       save_npc;
    logic       misalign;
    logic       taken;
    logic       misalign_hit;

    assign taken = Cond_True | Branch_Always;

`ifdef PCSEQ_ALIGN_CHECK_EN
    // A taken DCTI whose target is not word aligned is turned into a trap
    assign misalign_hit = Branch & taken & (Target_Low != 2'b00);
`else
    logic unused_target_low;
    assign unused_target_low = ^Target_Low;
    assign misalign_hit      = 1'b0;
`endif

    // Next-state and mux/load decode; Reset overrides everything combinationally
    always_comb begin
        state_d  = state_q;
        annul_d  = annul_q;
        cnt_d    = cnt_q;
        mux_pc   = 2'b00;
        mux_npc  = 2'b00;
        ld       = 1'b0;
        save_pc  = 1'b0;
        save_npc = 1'b0;
        misalign = 1'b0;
        case (state_q)
            S_RUN: begin
                if (Step) begin
                    if (annul_q) begin
                        // Annulled slot: advance sequentially, ignore Trap/Branch
                        ld      = 1'b1;
                        annul_d = 1'b0;
                    end else if (Trap) begin
                        state_d = S_TRAP;
                        cnt_d   = CNT_START;
                        annul_d = 1'b0;
                    end else if (misalign_hit) begin
                        misalign = 1'b1;
                        state_d  = S_TRAP;
                        cnt_d    = CNT_START;
                        annul_d  = 1'b0;
                    end else if (Branch) begin
                        ld = 1'b1;
                        if (taken) begin
                            mux_npc = 2'b01;
                            annul_d = Annul_Bit & Branch_Always;
                        end else begin
                            annul_d = Annul_Bit;
                        end
                    end else begin
                        ld      = 1'b1;
                        annul_d = 1'b0;
                    end
                end
            end
            S_TRAP: begin
                save_pc  = (cnt_q == CNT_START);
                save_npc = (cnt_q == CNT_SAVE_NPC);
                if (cnt_q == CNT_ZERO) begin
                    mux_pc  = 2'b10;
                    mux_npc = 2'b10;
                    ld      = 1'b1;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                // Reset vector: PC=0, nPC=4
                mux_pc  = 2'b11;
                mux_npc = 2'b11;
                ld      = 1'b1;
                state_d = S_RUN;
            end
        endcase
        if (Reset) begin
            mux_pc   = 2'b11;
            mux_npc  = 2'b11;
            ld       = 1'b0;
            save_pc  = 1'b0;
            save_npc = 1'b0;
            misalign = 1'b0;
        end
    end

    // State, annul flag and trap counter registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_RESET;
            annul_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            annul_q <= annul_d;
            cnt_q   <= cnt_d;
        end
    end

    assign MUX_PC   = mux_pc;
    assign MUX_nPC  = mux_npc;
    assign PC_Ld    = ld;
    assign nPC_Ld   = ld;
    assign Annul    = annul_q;
    assign Save_PC  = save_pc;
    assign Save_nPC = save_npc;
    assign State    = state_q;
    assign Misalign = misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    localparam int TRAP_CYCLES = 3;
`ifdef PCSEQ_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Step = 1'b0;
    logic       Branch = 1'b0;
    logic       Cond_True = 1'b0;
    logic       Branch_Always = 1'b0;
    logic       Annul_Bit = 1'b0;
    logic       Trap = 1'b0;
    logic [1:0] Target_Low = 2'b00;
    logic [1:0] MUX_PC;
    logic [1:0] MUX_nPC;
    logic       PC_Ld;
    logic       nPC_Ld;
    logic       Annul;
    logic       Save_PC;
    logic       Save_nPC;
    logic [1:0] State;
    logic       Misalign;

    pc_sequencer #(.TRAP_CYCLES(TRAP_CYCLES)) dut (
        .Clk(Clk), .Reset(Reset), .Step(Step), .Branch(Branch),
        .Cond_True(Cond_True), .Branch_Always(Branch_Always),
        .Annul_Bit(Annul_Bit), .Trap(Trap), .Target_Low(Target_Low),
        .MUX_PC(MUX_PC), .MUX_nPC(MUX_nPC), .PC_Ld(PC_Ld), .nPC_Ld(nPC_Ld),
        .Annul(Annul), .Save_PC(Save_PC), .Save_nPC(Save_nPC),
        .State(State), .Misalign(Misalign)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0=reset entry, 1=running, 2=trap; age counts cycles since trap entry
    int m_mode = 0;
    int m_age  = 0;
    bit m_annul = 1'b0;

    logic [11:0] exp_v;
    logic [11:0] dut_bundle;
    assign dut_bundle = {MUX_PC, MUX_nPC, PC_Ld, nPC_Ld, Annul, Save_PC, Save_nPC, State, Misalign};

    function automatic logic [11:0] model_out(input logic rst, stp, br, ct, ba, tr, input logic [1:0] tl);
        logic [1:0] mp, mn, st;
        logic ld, sp, sn, mis, an;
        mp = 2'b00; mn = 2'b00; ld = 1'b0; sp = 1'b0; sn = 1'b0; mis = 1'b0;
        an = m_annul;
        st = 2'(m_mode);
        if (rst) begin
            mp = 2'b11; mn = 2'b11; an = 1'b0; st = 2'b00;
        end else if (m_mode == 0) begin
            mp = 2'b11; mn = 2'b11; ld = 1'b1;
        end else if (m_mode == 1) begin
            if (stp) begin
                if (m_annul) ld = 1'b1;
                else if (tr) ld = 1'b0;
                else if (br && (ct || ba) && ALIGN_EN && tl != 2'b00) mis = 1'b1;
                else begin
                    ld = 1'b1;
                    if (br && (ct || ba)) mn = 2'b01;
                end
            end
        end else begin
            sp = (m_age == 1);
            sn = (m_age == 2);
            if (m_age == TRAP_CYCLES) begin mp = 2'b10; mn = 2'b10; ld = 1'b1; end
        end
        return {mp, mn, ld, ld, an, sp, sn, st, mis};
    endfunction

    task automatic model_advance(input logic rst, stp, br, ct, ba, ab, tr, input logic [1:0] tl);
        if (rst) begin
            m_mode = 0; m_annul = 1'b0; m_age = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (stp) begin
                if (m_annul) m_annul = 1'b0;
                else if (tr || (br && (ct || ba) && ALIGN_EN && tl != 2'b00)) begin
                    m_mode = 2; m_age = 1; m_annul = 1'b0;
                end else if (br) m_annul = (ct || ba) ? (ab && ba) : ab;
                else m_annul = 1'b0;
            end
        end else begin
            if (m_age == TRAP_CYCLES) begin m_mode = 1; m_age = 0; end
            else m_age = m_age + 1;
        end
    endtask

    // One cycle: drive at negedge, settle, record model expectation, advance model past the next posedge
    task automatic drive(input logic rst, stp, br, ct, ba, ab, tr, input logic [1:0] tl);
        @(negedge Clk);
        Reset = rst; Step = stp; Branch = br; Cond_True = ct;
        Branch_Always = ba; Annul_Bit = ab; Trap = tr; Target_Low = tl;
        if (rst) begin m_mode = 0; m_annul = 1'b0; m_age = 0; end
        #1;
        exp_v = model_out(rst, stp, br, ct, ba, tr, tl);
        model_advance(rst, stp, br, ct, ba, ab, tr, tl);
    endtask

    task automatic test_reset();
        @(negedge Clk); #1;
        checks++; if (dut_bundle !== 12'hF00) begin errors++; $display("FAIL reset_hold: got %h expected %h", dut_bundle, 12'hF00); end
        drive(0, 1, 1, 1, 0, 0, 1, 2'b00);
        checks++; if (dut_bundle !== 12'hFC0) begin errors++; $display("FAIL reset_entry: got %h expected %h", dut_bundle, 12'hFC0); end
        checks++; if (dut_bundle !== exp_v) begin errors++; $display("FAIL reset_entry_model: got %h expected %h", dut_bundle, exp_v); end
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
        checks++; if (dut_bundle !== 12'h002) begin errors++; $display("FAIL run_idle: got %h expected %h", dut_bundle, 12'h002); end
    endtask

    task automatic test_taken_branch();
        drive(0, 1, 1, 1, 0, 0, 0, 2'b00);
        checks++; if (dut_bundle[11:6] !== 6'b00_01_11) begin errors++; $display("FAIL taken_sel: got %b expected %b", dut_bundle[11:6], 6'b00_01_11); end
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
        checks++; if (Annul !== 1'b0) begin errors++; $display("FAIL taken_annul: got %b expected 0", Annul); end
    endtask

    task automatic test_annul_not_taken();
        drive(0, 1, 1, 0, 0, 1, 0, 2'b00);
        checks++; if (dut_bundle[11:6] !== 6'b00_00_11) begin errors++; $display("FAIL nt_sel: got %b expected %b", dut_bundle[11:6], 6'b00_00_11); end
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
        checks++; if (Annul !== 1'b1) begin errors++; $display("FAIL nt_annul_set: got %b expected 1", Annul); end
        drive(0, 1, 1, 1, 0, 0, 1, 2'b00);
        checks++; if (dut_bundle[11:6] !== 6'b00_00_11) begin errors++; $display("FAIL annulled_sel: got %b expected %b", dut_bundle[11:6], 6'b00_00_11); end
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
        checks++; if ({Annul, State} !== 3'b0_01) begin errors++; $display("FAIL annulled_notrap: got %b expected %b", {Annul, State}, 3'b0_01); end
    endtask

    task automatic test_branch_always_annul();
        drive(0, 1, 1, 0, 1, 1, 0, 2'b00);
        checks++; if (dut_bundle[11:6] !== 6'b00_01_11) begin errors++; $display("FAIL ba_sel: got %b expected %b", dut_bundle[11:6], 6'b00_01_11); end
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
        checks++; if (Annul !== 1'b1) begin errors++; $display("FAIL ba_annul_set: got %b expected 1", Annul); end
        drive(0, 1, 0, 0, 0, 0, 0, 2'b00);
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
        checks++; if (Annul !== 1'b0) begin errors++; $display("FAIL ba_annul_clear: got %b expected 0", Annul); end
    endtask

    task automatic test_trap();
        drive(0, 1, 0, 0, 0, 0, 1, 2'b00);
        checks++; if (dut_bundle[7:6] !== 2'b00) begin errors++; $display("FAIL trap_req_loads: got %b expected 00", dut_bundle[7:6]); end
        drive(0, 1, 0, 0, 0, 0, 1, 2'b00);
        checks++; if ({Save_PC, Save_nPC, State, PC_Ld} !== 5'b10_10_0) begin errors++; $display("FAIL trap_p1: got %b expected %b", {Save_PC, Save_nPC, State, PC_Ld}, 5'b10_10_0); end
        drive(0, 1, 0, 0, 0, 0, 0, 2'b00);
        checks++; if ({Save_PC, Save_nPC, PC_Ld} !== 3'b01_0) begin errors++; $display("FAIL trap_p2: got %b expected %b", {Save_PC, Save_nPC, PC_Ld}, 3'b01_0); end
        drive(0, 1, 0, 0, 0, 0, 0, 2'b00);
        checks++; if (dut_bundle[11:3] !== 9'b10_10_11_0_00) begin errors++; $display("FAIL trap_p3: got %b expected %b", dut_bundle[11:3], 9'b10_10_11_0_00); end
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
        checks++; if (State !== 2'b01) begin errors++; $display("FAIL trap_p4_state: got %b expected 01", State); end
    endtask

    task automatic test_reset_mid_trap();
        drive(0, 1, 0, 0, 0, 0, 1, 2'b00);
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
        drive(1, 0, 0, 0, 0, 0, 0, 2'b00);
        checks++; if (dut_bundle !== 12'hF00) begin errors++; $display("FAIL rst_mid_trap: got %h expected %h", dut_bundle, 12'hF00); end
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
        checks++; if (dut_bundle !== 12'hFC0) begin errors++; $display("FAIL rst_mid_trap_entry: got %h expected %h", dut_bundle, 12'hFC0); end
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
        checks++; if (State !== 2'b01) begin errors++; $display("FAIL rst_mid_trap_run: got %b expected 01", State); end
    endtask

    task automatic test_misalign();
        drive(0, 1, 1, 1, 0, 0, 0, 2'b10);
        checks++; if ({Misalign, PC_Ld, nPC_Ld} !== {ALIGN_EN, ~ALIGN_EN, ~ALIGN_EN}) begin errors++; $display("FAIL misalign_strobe: got %b expected %b", {Misalign, PC_Ld, nPC_Ld}, {ALIGN_EN, ~ALIGN_EN, ~ALIGN_EN}); end
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
        checks++; if (State !== (ALIGN_EN ? 2'b10 : 2'b01)) begin errors++; $display("FAIL misalign_state: got %b expected %b", State, ALIGN_EN ? 2'b10 : 2'b01); end
        for (int i = 0; i < TRAP_CYCLES; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 2'b00);
            checks++; if (dut_bundle !== exp_v) begin errors++; $display("FAIL misalign_drain: got %h expected %h", dut_bundle, exp_v); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                  ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
            checks++; if (dut_bundle !== exp_v) begin errors++; $display("FAIL random[%0d]: got %h expected %h", i, dut_bundle, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_taken_branch();
        test_annul_not_taken();
        test_branch_always_annul();
        test_trap();
        test_reset_mid_trap();
        test_misalign();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
